sprite_compositor: RTL and testbench



---
 rtl/sprite_compositor.sv | 216 +++++++++++++++++++++
 tb/tb_sprite_compositor.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// sprite_compositor: pipelined per-pixel sprite overlay for the HDMI path.
// Picks the highest-priority sprite covering the current pixel, fetches its
// texel from the shared sprite BRAM, and composites it over the tile
// background. It also runs the wild-battle screen transition
// (white/black flash, black hold, then battle screen).
module sprite_compositor #(
   parameter int           N_SPR        = 4,
   parameter int           SPR_W        = 32,
   parameter int           SPR_H        = 32,
   parameter int           ADDR_W       = 16,
   parameter int           SPR_BASE     = 32776,
   parameter int           RD_LAT       = 1,
   parameter logic [11:0]  TRANSP_KEY   = 12'h001,
   parameter int           FLASH_FRAMES = 4,
   parameter int           N_FLASH      = 3,
   parameter int           HOLD_FRAMES  = 30
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [9:0]          DrawX,
   input  logic [9:0]          DrawY,
   input  logic                frame_start,
   input  logic [11:0]         bg_rgb,
   input  logic [10*N_SPR-1:0] spr_x,
   input  logic [10*N_SPR-1:0] spr_y,
   input  logic [3*N_SPR-1:0]  spr_frame,
   input  logic [N_SPR-1:0]    spr_en,
   input  logic                battle_start,
   input  logic                battle_exit,
   output logic [ADDR_W-1:0]   bram_addr,
   input  logic [15:0]         bram_data,
   output logic [3:0]          Red,
   output logic [3:0]          Green,
   output logic [3:0]          Blue,
   output logic                in_battle,
   output logic                trans_busy
);

   localparam logic [9:0]  SPR_W10       = 10'(SPR_W);
   localparam logic [9:0]  SPR_H10       = 10'(SPR_H);
   localparam logic [31:0] SPR_W32       = 32'(SPR_W);
   localparam logic [31:0] SPR_BASE32    = 32'(SPR_BASE);
   // Each animation frame occupies one extra word beyond its texels.
   localparam logic [31:0] FRAME_WORDS32 = 32'(SPR_W * SPR_H + 1);

   localparam int FC_MAX = (FLASH_FRAMES > HOLD_FRAMES) ? FLASH_FRAMES : HOLD_FRAMES;
   localparam int FC_W   = $clog2(FC_MAX + 1);
   localparam int PH_W   = $clog2(2 * N_FLASH + 1);
   localparam logic [FC_W-1:0] FLASH_LAST = FC_W'(FLASH_FRAMES - 1);
   localparam logic [FC_W-1:0] HOLD_LAST  = FC_W'(HOLD_FRAMES - 1);
   localparam logic [PH_W-1:0] PH_LAST    = PH_W'(2 * N_FLASH - 1);

   typedef enum logic [1:0] {IDLE, FLASH, HOLD, BATTLE} state_t;

   state_t          state;
   logic [FC_W-1:0] fc;
   logic [PH_W-1:0] ph_cnt;
   logic            phase_white;

   logic [9:0]        dx [N_SPR];
   logic [9:0]        dy [N_SPR];
   logic [N_SPR-1:0]  hit_vec;
   logic              win_hit;
   logic [ADDR_W-1:0] win_addr;
   logic [31:0]       addr_full;

   logic        hit_s0;
   logic        valid_s0;
   logic [11:0] bg_s0;
   logic        hit_d   [RD_LAT];
   logic        valid_d [RD_LAT];
   logic [11:0] bg_d    [RD_LAT];

   logic [11:0] texel;
   logic        unused_bits;

   assign texel       = bram_data[11:0];
   assign unused_bits = ^bram_data[15:12];

   // Per-slot offsets; unsigned wrap makes pixels left of/above a sprite miss.
   always_comb begin
      for (int i = 0; i < N_SPR; i++) begin
         dx[i]      = DrawX - spr_x[10*i +: 10];
         dy[i]      = DrawY - spr_y[10*i +: 10];
         hit_vec[i] = spr_en[i] && (dx[i] < SPR_W10) && (dy[i] < SPR_H10);
      end
   end

   // Priority select: scanning from the top slot down leaves the lowest hit index.
   always_comb begin
      win_hit   = 1'b0;
      addr_full = '0;
      for (int i = N_SPR - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            win_hit   = 1'b1;
            addr_full = SPR_BASE32 + 32'(spr_frame[3*i +: 3]) * FRAME_WORDS32
                        + 32'(dy[i]) * SPR_W32 + 32'(dx[i]);
         end
      end
      win_addr = addr_full[ADDR_W-1:0];
   end

   // Stage 0: register the BRAM address, hit flag and background.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         bram_addr <= '0;
         hit_s0    <= 1'b0;
         bg_s0     <= '0;
         valid_s0  <= 1'b0;
      end else begin
         bram_addr <= win_addr;
         hit_s0    <= win_hit;
         bg_s0     <= bg_rgb;
         valid_s0  <= 1'b1;
      end
   end

   // Stages 1..RD_LAT: carry hit and background alongside the BRAM read.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < RD_LAT; i++) begin
            hit_d[i]   <= 1'b0;
            valid_d[i] <= 1'b0;
            bg_d[i]    <= '0;
         end
      end else begin
         hit_d[0]   <= hit_s0;
         valid_d[0] <= valid_s0;
         bg_d[0]    <= bg_s0;
         for (int i = 1; i < RD_LAT; i++) begin
            hit_d[i]   <= hit_d[i-1];
            valid_d[i] <= valid_d[i-1];
            bg_d[i]    <= bg_d[i-1];
         end
      end
   end

   // Output stage: transition screens override; a keyed texel falls back to background only.
   always_ff @(posedge Clk) begin
      if (Reset || !valid_d[RD_LAT-1]) begin
         {Red, Green, Blue} <= 12'h000;
      end else if (state == FLASH && phase_white) begin
         {Red, Green, Blue} <= 12'hFFF;
      end else if (state == FLASH || state == HOLD) begin
         {Red, Green, Blue} <= 12'h000;
      end else if (state == BATTLE) begin
         {Red, Green, Blue} <= 12'hFFF;
      end else if (hit_d[RD_LAT-1] && texel != TRANSP_KEY) begin
         {Red, Green, Blue} <= texel;
      end else begin
         {Red, Green, Blue} <= bg_d[RD_LAT-1];
      end
   end

   // Battle transition FSM, counting frame_start pulses.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         fc          <= '0;
         ph_cnt      <= '0;
         phase_white <= 1'b0;
         in_battle   <= 1'b0;
         trans_busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (battle_start) begin
                  state       <= FLASH;
                  fc          <= '0;
                  ph_cnt      <= '0;
                  phase_white <= 1'b1;
                  trans_busy  <= 1'b1;
               end
            end
            FLASH: begin
               if (frame_start) begin
                  if (fc == FLASH_LAST) begin
                     fc <= '0;
                     if (ph_cnt == PH_LAST) begin
                        state  <= HOLD;
                        ph_cnt <= '0;
                     end else begin
                        ph_cnt      <= ph_cnt + 1'b1;
                        phase_white <= ~phase_white;
                     end
                  end else begin
                     fc <= fc + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (frame_start) begin
                  if (fc == HOLD_LAST) begin
                     state      <= BATTLE;
                     fc         <= '0;
                     trans_busy <= 1'b0;
                     in_battle  <= 1'b1;
                  end else begin
                     fc <= fc + 1'b1;
                  end
               end
            end
            BATTLE: begin
               if (battle_exit) begin
                  state     <= IDLE;
                  in_battle <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: randomized scoreboard bench for sprite_compositor.
// The driver computes expected responses from a pixel/rectangle reference
// model and a frame-count view of the battle transition, queueing them with
// the cycle they are due; an independent monitor compares every cycle.
module tb_sprite_compositor;

   localparam int N_SPR        = 4;
   localparam int SPR_W        = 32;
   localparam int SPR_H        = 32;
   localparam int ADDR_W       = 16;
   localparam int SPR_BASE     = 32776;
   localparam int RD_LAT       = 1;
   localparam int FLASH_FRAMES = 4;
   localparam int N_FLASH      = 3;
   localparam int HOLD_FRAMES  = 30;
   localparam int FLASH_END    = 2 * N_FLASH * FLASH_FRAMES;
   localparam int BATTLE_AT    = FLASH_END + HOLD_FRAMES;

   logic                Clk = 1'b0;
   logic                Reset = 1'b1;
   logic [9:0]          DrawX = '0;
   logic [9:0]          DrawY = '0;
   logic                frame_start = 1'b0;
   logic [11:0]         bg_rgb = '0;
   logic [10*N_SPR-1:0] spr_x = '0;
   logic [10*N_SPR-1:0] spr_y = '0;
   logic [3*N_SPR-1:0]  spr_frame = '0;
   logic [N_SPR-1:0]    spr_en = '0;
   logic                battle_start = 1'b0;
   logic                battle_exit = 1'b0;
   logic [ADDR_W-1:0]   bram_addr;
   logic [15:0]         bram_data;
   logic [3:0]          Red, Green, Blue;
   logic                in_battle, trans_busy;

   sprite_compositor #(
      .N_SPR(N_SPR), .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W),
      .SPR_BASE(SPR_BASE), .RD_LAT(RD_LAT), .TRANSP_KEY(12'h001),
      .FLASH_FRAMES(FLASH_FRAMES), .N_FLASH(N_FLASH), .HOLD_FRAMES(HOLD_FRAMES)
   ) dut (
      .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
      .frame_start(frame_start), .bg_rgb(bg_rgb), .spr_x(spr_x), .spr_y(spr_y),
      .spr_frame(spr_frame), .spr_en(spr_en), .battle_start(battle_start),
      .battle_exit(battle_exit), .bram_addr(bram_addr), .bram_data(bram_data),
      .Red(Red), .Green(Green), .Blue(Blue), .in_battle(in_battle),
      .trans_busy(trans_busy)
   );

   typedef struct {
      int          due;
      logic [15:0] val;
   } exp_t;

   typedef struct {
      logic        hit;
      logic [11:0] tex;
      logic [11:0] bg;
      logic        killed;
   } pix_t;

   exp_t q_addr[$];
   exp_t q_rgb[$];
   exp_t q_fsm[$];
   pix_t pend[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   bit m_active = 1'b0;
   int m_n      = 0;

   int               sx[N_SPR];
   int               sy[N_SPR];
   int               sf[N_SPR];
   logic [N_SPR-1:0] sen = '0;

   logic [15:0] rd_q [RD_LAT];

   // Pixel clock.
   initial forever #5 Clk = ~Clk;

   // Cycle index: number of rising edges seen so far.
   always @(posedge Clk) cyc <= cyc + 1;

   // Sprite BRAM contents: a fixed hash with a sprinkling of transparent texels.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      logic [31:0] h;
      h = 32'(a) * 32'd2531 + 32'd77;
      if (a % 16'd7 == 16'd3) return {a[3:0], 12'h001};
      if (h[11:0] == 12'h001) return {a[3:0], 12'h002};
      return {a[3:0], h[11:0]};
   endfunction

   // Sprite BRAM with RD_LAT cycles of read latency.
   always @(posedge Clk) begin
      rd_q[0] <= mem_word(bram_addr);
      for (int i = 1; i < RD_LAT; i++) rd_q[i] <= rd_q[i-1];
   end
   assign bram_data = rd_q[RD_LAT-1];

   // Displayed colour given how many frames have passed since the battle request.
   function automatic logic [11:0] screen_colour(input bit act, input int n,
                                                 input logic hit, input logic [11:0] tex,
                                                 input logic [11:0] bg);
      if (act && n < FLASH_END) return ((n / FLASH_FRAMES) % 2 == 0) ? 12'hFFF : 12'h000;
      if (act && n < BATTLE_AT) return 12'h000;
      if (act) return 12'hFFF;
      if (hit && tex != 12'h001) return tex;
      return bg;
   endfunction

   task automatic check_output(input string name, input logic [15:0] act,
                               input logic [15:0] expv, input int due);
      checks++;
      if (due != cyc || act !== expv) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h (due cycle %0d, cycle %0d)",
                  name, act, expv, due, cyc);
      end
   endtask

   // Monitor: compare every queued expectation on the falling edge of its cycle.
   always @(negedge Clk) begin
      exp_t e;
      if (q_addr.size() > 0 && q_addr[0].due <= cyc) begin
         e = q_addr.pop_front();
         check_output("bram_addr", 16'(bram_addr), e.val, e.due);
      end
      if (q_fsm.size() > 0 && q_fsm[0].due <= cyc) begin
         e = q_fsm.pop_front();
         check_output("in_battle/trans_busy", {14'b0, in_battle, trans_busy}, e.val, e.due);
      end
      if (q_rgb.size() > 0 && q_rgb[0].due <= cyc) begin
         e = q_rgb.pop_front();
         check_output("rgb", {4'b0, Red, Green, Blue}, e.val, e.due);
      end
   end

   // Drive one cycle of inputs and queue everything the reference model predicts.
   task automatic apply_stimulus(input int x, input int y, input logic [11:0] bg,
                                 input logic fs, input logic bs, input logic be,
                                 input logic rst);
      pix_t        p;
      exp_t        e;
      logic [15:0] word;
      int          addr;
      bit          prev_act;
      int          prev_n;
      bit          in_b;
      bit          busy;
      @(posedge Clk);
      #1;
      DrawX        = 10'(x);
      DrawY        = 10'(y);
      bg_rgb       = bg;
      frame_start  = fs;
      battle_start = bs;
      battle_exit  = be;
      Reset        = rst;
      spr_en       = sen;
      for (int i = 0; i < N_SPR; i++) begin
         spr_x[10*i +: 10]   = 10'(sx[i]);
         spr_y[10*i +: 10]   = 10'(sy[i]);
         spr_frame[3*i +: 3] = 3'(sf[i]);
      end

      p.hit    = 1'b0;
      p.bg     = bg;
      p.killed = 1'b0;
      addr     = 0;
      for (int i = 0; i < N_SPR; i++) begin
         if (!p.hit && sen[i] && x >= sx[i] && x < sx[i] + SPR_W &&
             y >= sy[i] && y < sy[i] + SPR_H) begin
            p.hit = 1'b1;
            addr  = (SPR_BASE + sf[i] * (SPR_W * SPR_H + 1)
                     + (y - sy[i]) * SPR_W + (x - sx[i])) % (1 << ADDR_W);
         end
      end
      word  = mem_word(16'(addr));
      p.tex = word[11:0];

      e.due = cyc + 1;
      e.val = rst ? 16'h0 : 16'(addr);
      q_addr.push_back(e);

      pend.push_back(p);
      if (rst) foreach (pend[k]) pend[k].killed = 1'b1;

      prev_act = m_active;
      prev_n   = m_n;
      if (rst) begin
         m_active = 1'b0;
         m_n      = 0;
      end else if (!m_active) begin
         if (bs) begin
            m_active = 1'b1;
            m_n      = 0;
         end
      end else if (m_n >= BATTLE_AT && be) begin
         m_active = 1'b0;
      end else if (fs) begin
         m_n++;
      end
      in_b  = m_active && m_n >= BATTLE_AT;
      busy  = m_active && m_n < BATTLE_AT;
      e.due = cyc + 1;
      e.val = {14'b0, in_b, busy};
      q_fsm.push_back(e);

      if (pend.size() == RD_LAT + 2) begin
         p     = pend.pop_front();
         e.due = cyc + 1;
         e.val = p.killed ? 16'h0 : {4'b0, screen_colour(prev_act, prev_n, p.hit, p.tex, p.bg)};
         q_rgb.push_back(e);
      end
   endtask

   task automatic random_pixel(input logic fs, input logic bs, input logic be, input logic rst);
      apply_stimulus($urandom_range(0, 260), $urandom_range(0, 260), 12'($urandom),
                     fs, bs, be, rst);
   endtask

   task automatic shuffle_slots();
      for (int i = 0; i < N_SPR; i++) begin
         sx[i] = $urandom_range(0, 220);
         sy[i] = $urandom_range(0, 220);
         sf[i] = $urandom_range(0, 7);
      end
      sen = N_SPR'($urandom);
   endtask

   // Run n frames, each frame_start separated by two idle pixels.
   task automatic run_frames(input int n, input int second_start_at, input int exit_at);
      for (int f = 0; f < n; f++) begin
         random_pixel(1'b0, 1'b0, 1'b0, 1'b0);
         random_pixel(1'b0, 1'b0, 1'b0, 1'b0);
         random_pixel(1'b1, f == second_start_at, f == exit_at, 1'b0);
      end
   endtask

   // Watchdog so the bench cannot hang.
   initial begin
      #1ms;
      $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      for (int i = 0; i < N_SPR; i++) begin
         sx[i] = 0;
         sy[i] = 0;
         sf[i] = 0;
      end

      $display("[TB] reset held for 3 cycles");
      repeat (3) apply_stimulus(0, 0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] single sprite address and texel");
      sen   = 4'b0001;
      sx[0] = 100;
      sy[0] = 100;
      sf[0] = 2;
      apply_stimulus(105, 103, 12'h123, 1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(99, 103, 12'h456, 1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(131, 131, 12'h789, 1'b0, 1'b0, 1'b0, 1'b0);
      apply_stimulus(132, 100, 12'habc, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] overlapping sprites with transparent texels");
      sen   = 4'b0011;
      sx[0] = 200;
      sy[0] = 200;
      sf[0] = 1;
      sx[1] = 205;
      sy[1] = 205;
      sf[1] = 3;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 27; c++)
            apply_stimulus(205 + c, 205 + r, 12'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] randomized compositing");
      shuffle_slots();
      for (int k = 0; k < 2000; k++) begin
         if ($urandom_range(0, 15) == 0) shuffle_slots();
         random_pixel($urandom_range(0, 7) == 0, $urandom_range(0, 499) == 0,
                      $urandom_range(0, 29) == 0, $urandom_range(0, 799) == 0);
      end

      $display("[TB] full battle transition");
      apply_stimulus(0, 0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1);
      shuffle_slots();
      random_pixel(1'b0, 1'b1, 1'b0, 1'b0);
      run_frames(BATTLE_AT + 4, 5, 10);
      random_pixel(1'b0, 1'b1, 1'b1, 1'b0);
      repeat (4) random_pixel(1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] reset during hold, exit while idle");
      random_pixel(1'b0, 1'b1, 1'b0, 1'b0);
      run_frames(FLASH_END + 6, -1, -1);
      random_pixel(1'b0, 1'b0, 1'b0, 1'b1);
      random_pixel(1'b0, 1'b0, 1'b1, 1'b0);
      repeat (RD_LAT + 6) random_pixel(1'b0, 1'b0, 1'b0, 1'b0);

      for (int w = 0; w < 20; w++) begin
         if (q_addr.size() == 0 && q_rgb.size() == 0 && q_fsm.size() == 0) break;
         @(negedge Clk);
      end
      @(posedge Clk);
      if (q_addr.size() != 0 || q_rgb.size() != 0 || q_fsm.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain: got %0d pending expectations, expected 0",
                  q_addr.size() + q_rgb.size() + q_fsm.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
